// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Pushbutton front end. Each bit passes through a 2-flop
//               synchronizer, is sampled on a shared timer tick by a
//               saturating debounce counter, and drives an edge detector
//               that emits one-cycle press/release pulses.
//               Optional feature macro: BUTTON_REPEAT_EN adds per-bit
//               auto-repeat press pulses while a button stays held.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = 25000,
  parameter int PULSE_CNT_MAX  = 150,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_PERIOD  = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] button_in,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  // Timer needs at least one bit even when it never leaves zero.
  localparam int TW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int CW = $clog2(PULSE_CNT_MAX + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(PULSE_CNT_MAX);

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] press_edge;
  logic [TW-1:0]    timer;
  logic             tick;

  // Two-stage synchronizer; nothing else looks at the raw inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= button_in;
      sync_q    <= sync_meta;
    end
  end

  // Shared sample timer: free-running 0..SAMPLE_CNT_MAX-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (tick) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  assign tick = (timer == TIMER_LAST);

  // Previous debounced level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
    end else begin
      prev <= debounced;
    end
  end

  assign press_edge    = debounced & ~prev;
  assign release_pulse = ~debounced & prev;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      logic [CW-1:0] cnt;

      // Saturating debounce counter; any low sample restarts qualification.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt <= '0;
        end else if (tick) begin
          if (!sync_q[i]) begin
            cnt <= '0;
          end else if (cnt != CNT_FULL) begin
            cnt <= cnt + CW'(1);
          end
        end
      end

      assign debounced[i] = (cnt == CNT_FULL);

`ifdef BUTTON_REPEAT_EN
      localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RW   = $clog2(RMAX + 1);
      localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
      localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

      logic [RW-1:0] rep_cnt;
      logic          rep_running;  // 0: waiting out the initial delay
      logic          rep_fire;

      // Auto-repeat: count ticks while held, fire one cycle after the target tick.
      always_ff @(posedge clk) begin
        if (rst || !debounced[i] || press_edge[i]) begin
          rep_cnt     <= '0;
          rep_running <= 1'b0;
          rep_fire    <= 1'b0;
        end else begin
          rep_fire <= 1'b0;
          if (tick) begin
            if (rep_cnt == (rep_running ? PERIOD_LAST : DELAY_LAST)) begin
              rep_cnt     <= '0;
              rep_running <= 1'b1;
              rep_fire    <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + RW'(1);
            end
          end
        end
      end

      // Gating with the live level kills a repeat that lands on the release tick.
      assign press_pulse[i] = press_edge[i] | (rep_fire & debounced[i]);
`else
      assign press_pulse[i] = press_edge[i];
`endif
    end : g_bit
  endgenerate

`ifndef BUTTON_REPEAT_EN
  // Repeat timing parameters have no meaning without the repeat feature.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] button_in = 2'b00;
  logic [1:0] debounced;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;   // edges since last reset edge; DUT ticks on edges with cyc%4==0

  int lat;
  int n_press;
  int n_rel;
  int quiet;
  logic [1:0] first_val;
  int ptimes[$];

  always #5 clk = ~clk;

  button_conditioner #(
    .WIDTH          (2),
    .SAMPLE_CNT_MAX (4),
    .PULSE_CNT_MAX  (3),
    .REPEAT_DELAY   (5),
    .REPEAT_PERIOD  (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .button_in     (button_in),
    .debounced     (debounced),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (rst) cyc = 0;
    else cyc++;
    #1;
  endtask

  initial begin
    // 1. Reset with both buttons pressed: outputs stay low.
    rst = 1'b1;
    button_in = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_debounced", debounced, 2'b00);
      check("rst_press", press_pulse, 2'b00);
      check("rst_release", release_pulse, 2'b00);
    end
    button_in = 2'b00;
    rst = 1'b0;
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (debounced != 0 || press_pulse != 0 || release_pulse != 0) quiet++;
    end
    check("idle_quiet", quiet, 0);

    // 2. Clean rise on bit0: one press pulse, 11..15 cycles after the rise.
    button_in = 2'b01;
    lat = 0; n_press = 0; n_rel = 0; quiet = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (press_pulse[0]) begin
        n_press++;
        if (lat == 0) lat = i;
      end
      if (release_pulse[0]) n_rel++;
      if (press_pulse[1] || debounced[1] || release_pulse[1]) quiet++;
    end
    check("rise_press_count", n_press, 1);
    check("rise_latency_window", (lat >= 11 && lat <= 15), 1);
    check("rise_debounced", debounced, 2'b01);
    check("rise_no_release", n_rel, 0);
    check("rise_bit1_quiet", quiet, 0);

    // 4. Release: one release pulse within 7 cycles of the fall.
    button_in = 2'b00;
    lat = 0; n_press = 0; n_rel = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (release_pulse[0]) begin
        n_rel++;
        if (lat == 0) lat = i;
      end
      if (press_pulse != 0) n_press++;
    end
    check("rel_count", n_rel, 1);
    check("rel_latency_window", (lat >= 1 && lat <= 7), 1);
    check("rel_no_press", n_press, 0);
    check("rel_debounced", debounced, 2'b00);

    // 3. Bounce aligned so that the low gap lands on a sample tick.
    for (int i = 0; i < 4 && (cyc % 4) != 2; i++) step();
    n_press = 0; quiet = 0;
    button_in = 2'b01;
    for (int i = 0; i < 6; i++) begin
      step();
      if (press_pulse != 0) n_press++;
      if (debounced != 0) quiet++;
    end
    button_in = 2'b00;
    for (int i = 0; i < 2; i++) begin
      step();
      if (press_pulse != 0) n_press++;
      if (debounced != 0) quiet++;
    end
    button_in = 2'b01;
    for (int i = 0; i < 6; i++) begin
      step();
      if (press_pulse != 0) n_press++;
      if (debounced != 0) quiet++;
    end
    button_in = 2'b00;
    for (int i = 0; i < 12; i++) begin
      step();
      if (press_pulse != 0) n_press++;
      if (debounced != 0) quiet++;
    end
    check("bounce_no_press", n_press, 0);
    check("bounce_debounced_low", quiet, 0);

    // 5. Both bits together, then reset while held and re-qualify.
    button_in = 2'b11;
    lat = 0; first_val = 2'b00;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (press_pulse != 0 && lat == 0) begin
        lat = i;
        first_val = press_pulse;
      end
    end
    check("both_press_value", first_val, 2'b11);
    check("both_latency_window", (lat >= 11 && lat <= 15), 1);
    check("both_debounced", debounced, 2'b11);

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("midrst_debounced", debounced, 2'b00);
      check("midrst_press", press_pulse, 2'b00);
      check("midrst_release", release_pulse, 2'b00);
    end
    rst = 1'b0;
    lat = 0; first_val = 2'b00; n_rel = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (press_pulse != 0 && lat == 0) begin
        lat = i;
        first_val = press_pulse;
      end
      if (release_pulse != 0) n_rel++;
    end
    check("rerst_press_value", first_val, 2'b11);
    check("rerst_latency_window", (lat >= 11 && lat <= 15), 1);
    check("rerst_no_release", n_rel, 0);

    // Release both and let everything settle.
    button_in = 2'b00;
    n_rel = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (release_pulse == 2'b11) n_rel++;
    end
    check("both_release_together", n_rel, 1);

    // 6. Long hold on bit0: repeat cadence (or single pulse without repeat).
    button_in = 2'b01;
    ptimes.delete();
    for (int i = 1; i <= 80; i++) begin
      step();
      if (press_pulse[0]) ptimes.push_back(i);
    end
`ifdef BUTTON_REPEAT_EN
    begin
      int d1;
      int wrong;
      d1 = (ptimes.size() >= 2) ? (ptimes[1] - ptimes[0]) : -1;
      wrong = 0;
      for (int k = 2; k < ptimes.size(); k++)
        if (ptimes[k] - ptimes[k-1] != 8) wrong++;
      check("hold_enough_pulses", (ptimes.size() >= 5), 1);
      check("hold_first_repeat_gap", d1, 20);
      check("hold_period_gaps", wrong, 0);
    end
`else
    check("hold_single_pulse", ptimes.size(), 1);
`endif
    check("hold_first_window",
          (ptimes.size() >= 1) ? ((ptimes[0] >= 11 && ptimes[0] <= 15) ? 1 : 0) : 0, 1);

    button_in = 2'b00;
    n_press = 0; n_rel = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (press_pulse != 0) n_press++;
      if (release_pulse[0]) n_rel++;
    end
    check("hold_release_no_press", n_press, 0);
    check("hold_release_count", n_rel, 1);
    check("final_debounced", debounced, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
